router_pkt_reader: RTL
======================

// Module: router_pkt_reader
// PURPOSE
// - Destination-side drain engine for one router output FIFO; the read end of the packet stream the FIFO stores.
// - Pulls bytes from the FIFO, delineates packets: header {len[7:2],addr[1:0]}, len payload bytes, 1 parity byte.
// - Checks XOR parity and forwards bytes to the downstream client over a valid/ready stream with sop/eop marks.
// - Keeps packet and error counters.
// PARAMETERS
// - DW       8   data width; header/parity format fixed to 8 bits
// - CNT_W    16  width of pkt_cnt
// - ERR_W    8   width of err_cnt (saturating)
// PORTS
// - clk         in   1      single clock, rising edge
// - resetn      in   1      asynchronous active-low reset
// - soft_reset  in   1      synchronous abort; same pulse that clears the FIFO
// - empty       in   1      FIFO empty flag
// - fifo_data   in   DW     FIFO dataout; valid 1 cycle after read_enb sampled high with empty=0
// - read_enb    out  1      FIFO read strobe
// - pkt_data    out  DW     byte to client
// - pkt_valid   out  1      pkt_data/sop/eop/parity_err valid
// - pkt_ready   in   1      client accepts when pkt_valid&pkt_ready
// - sop         out  1      current byte is header
// - eop         out  1      current byte is parity
// - parity_err  out  1      qualified by eop: running XOR != parity byte
// - pkt_addr    out  2      addr field of current packet, held until next header
// - pkt_len     out  6      len field of current packet, held until next header
// - pkt_cnt     out  CNT_W  packets completed (wraps)
// - err_cnt     out  ERR_W  parity errors (saturates at all-ones)
// BEHAVIOUR
// - Reset: read_enb=0, pkt_valid=0, sop=0, eop=0, parity_err=0, pkt_addr=0, pkt_len=0, counters=0; FSM=HDR; buffer empty.
// - Read issue: read_enb = !empty && !soft_reset && (occ + inflight) < 2.
//   - occ: 2-entry output skid buffer occupancy; inflight: read issued last cycle.
//   - Sustains 1 byte/clk when pkt_ready=1. Never reads an empty FIFO.
// - Latency: FIFO byte appears on pkt_data 2 cycles after its read_enb when the buffer is empty.
// - Byte classification at FIFO-data capture (one-hot FSM):
//   - HDR: byte is header; load len/addr; par<=byte; rem<=len.
//     - Go PAY if len!=0, else PAR.
//   - PAY: par^=byte; rem--; go PAR when rem==1.
//   - PAR: parity byte; err=(par!=byte); go HDR.
// - Outputs are stored per entry; pkt_data/sop/eop/parity_err come from the buffer head.
//   - pkt_addr/pkt_len update when the header is captured.
// - Handshake: pkt_valid stays high and pkt_data stable until pkt_ready. No bubble insertion while data is buffered.
// - Counters update on the eop transfer (valid&ready&eop): pkt_cnt+1; err_cnt+1 if parity_err and not saturated.
// - Boundaries:
//   - len=0 packet: exactly 2 bytes; header sop, parity eop.
//   - len=63: 65 bytes.
//   - Back-to-back packets with no gap; the header following a parity byte is recognised in the next capture.
//   - empty toggling mid-packet: FSM holds position, no byte lost or duplicated.
//   - pkt_ready low with buffer full: read_enb deasserts. The in-flight byte fits because occ+inflight<=2.
//   - soft_reset (any state): next edge clears buffer, drops in-flight byte, FSM=HDR, pkt_valid=0.
//     - Counters, pkt_addr and pkt_len are kept.
//   - resetn low mid-packet: all state to reset values immediately.
// TESTING
// - Stream header 0x49, payload 0..17, parity 0x48, ready=1:
//   - 20 beats; sop on beat 0, eop on beat 19; parity_err=0; pkt_addr=1, pkt_len=18; pkt_cnt=1.
// - Same packet, parity 0x00:
//   - eop beat with parity_err=1; err_cnt=1; pkt_cnt=1.
// - Header 0x02 (len 0, addr 2), parity 0x02:
//   - 2 beats, sop then eop, parity_err=0.
// - ready toggled 1/0 every cycle plus empty gaps during an 18-byte packet:
//   - output sequence identical to the FIFO input; read_enb never high with empty=1.
// - soft_reset after payload byte 5:
//   - pkt_valid=0 next cycle; the next header 0x05 gets sop and is decoded as addr 1, len 1.
// - 256 corrupt-parity packets:
//   - err_cnt holds 0xFF; pkt_cnt=256.

Source files
------------

// File: rtl/router_pkt_reader.sv
// Drains one router output FIFO, delineates {hdr, payload, parity} packets, checks parity, streams bytes out.
// Latency: a FIFO byte reaches pkt_data 2 cycles after its read_enb when the skid buffer is empty.
// Backpressure: 2-entry skid buffer; read_enb stalls once buffered plus in-flight bytes would exceed 2.
module router_pkt_reader #(
   parameter int DW    = 8,
   parameter int CNT_W = 16,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             soft_reset,
   input  logic             empty,
   input  logic [DW-1:0]    fifo_data,
   output logic             read_enb,
   output logic [DW-1:0]    pkt_data,
   output logic             pkt_valid,
   input  logic             pkt_ready,
   output logic             sop,
   output logic             eop,
   output logic             parity_err,
   output logic [1:0]       pkt_addr,
   output logic [5:0]       pkt_len,
   output logic [CNT_W-1:0] pkt_cnt,
   output logic [ERR_W-1:0] err_cnt
);

   typedef enum logic [2:0] {
      ST_HDR = 3'b001,
      ST_PAY = 3'b010,
      ST_PAR = 3'b100
   } state_t;

   state_t          state;
   logic [DW-1:0]   par;
   logic [5:0]      rem;

   logic            inflight;
   logic [1:0]      occ;
   logic            hd;
   logic [DW-1:0]   ent_dat [2];
   logic [1:0]      ent_sop;
   logic [1:0]      ent_eop;
   logic [1:0]      ent_err;

   logic            pop;
   logic            push;
   logic [1:0]      occ_eff;
   logic [1:0]      fill;
   logic            wr;
   logic            cap_sop;
   logic            cap_eop;
   logic            cap_err;

   assign pkt_valid = (occ != 2'd0);
   assign pop       = pkt_valid & pkt_ready;
   assign push      = inflight & ~soft_reset;

   // The entry leaving this cycle is not counted, so a streaming client gets one byte per clock.
   assign occ_eff   = occ - {1'b0, pop};
   assign fill      = occ_eff + {1'b0, inflight};
   assign read_enb  = ~empty & ~soft_reset & (fill < 2'd2);

   // Next free slot sits occ entries past the head; when full, the slot being popped is reused.
   assign wr        = hd ^ occ[0];

   // Classification of the byte arriving from the FIFO this cycle, straight from the one-hot state.
   assign cap_sop   = state[0];
   assign cap_eop   = state[2];
   assign cap_err   = state[2] & (par != fifo_data);

   assign pkt_data   = ent_dat[hd];
   assign sop        = pkt_valid & ent_sop[hd];
   assign eop        = pkt_valid & ent_eop[hd];
   assign parity_err = pkt_valid & ent_eop[hd] & ent_err[hd];

   // Packet framing FSM: walks header, payload and parity on each captured FIFO byte.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= ST_HDR;
         par      <= '0;
         rem      <= '0;
         pkt_addr <= '0;
         pkt_len  <= '0;
      end else if (soft_reset) begin
         state    <= ST_HDR;
      end else if (inflight) begin
         case (state)
            ST_HDR: begin
               pkt_len  <= fifo_data[7:2];
               pkt_addr <= fifo_data[1:0];
               par      <= fifo_data;
               rem      <= fifo_data[7:2];
               state    <= (fifo_data[7:2] != 6'd0) ? ST_PAY : ST_PAR;
            end
            ST_PAY: begin
               par <= par ^ fifo_data;
               rem <= rem - 6'd1;
               if (rem == 6'd1) state <= ST_PAR;
            end
            ST_PAR: begin
               state <= ST_HDR;
            end
            default: begin
               state <= ST_HDR;
            end
         endcase
      end
   end

   // Skid buffer: captures the in-flight byte with its marks, pops on handshake, flushed by soft_reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         inflight   <= 1'b0;
         occ        <= 2'd0;
         hd         <= 1'b0;
         ent_dat[0] <= '0;
         ent_dat[1] <= '0;
         ent_sop    <= 2'b00;
         ent_eop    <= 2'b00;
         ent_err    <= 2'b00;
      end else begin
         inflight <= read_enb;
         if (soft_reset) begin
            occ <= 2'd0;
         end else begin
            if (push) begin
               ent_dat[wr] <= fifo_data;
               ent_sop[wr] <= cap_sop;
               ent_eop[wr] <= cap_eop;
               ent_err[wr] <= cap_err;
            end
            occ <= occ_eff + {1'b0, push};
            if (pop) hd <= ~hd;
         end
      end
   end

   // Packet and saturating error counters advance when the parity byte is accepted downstream.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pkt_cnt <= '0;
         err_cnt <= '0;
      end else if (pop && ent_eop[hd]) begin
         pkt_cnt <= pkt_cnt + CNT_W'(1);
         if (ent_err[hd] && (err_cnt != {ERR_W{1'b1}})) err_cnt <= err_cnt + ERR_W'(1);
      end
   end

endmodule
